// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: N masters, M address-decoded slaves, round-robin arbitration.
// Optional stalled-slave watchdog is built when WB_SHARED_BUS_TIMEOUT_EN is defined.
module wb_shared_bus #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned N_SLAVES  = 8,
  parameter int unsigned ADR_W     = 32,
  parameter int unsigned DAT_W     = 32,
  parameter logic [N_SLAVES*ADR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADR_W-1:0] SLAVE_MASK = '0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTERS*ADR_W-1:0]     m_adr_i,
  input  logic [N_MASTERS*DAT_W-1:0]     m_dat_i,
  input  logic [N_MASTERS*DAT_W/8-1:0]   m_sel_i,
  input  logic [N_MASTERS-1:0]           m_we_i,
  input  logic [N_MASTERS-1:0]           m_cyc_i,
  input  logic [N_MASTERS-1:0]           m_stb_i,
  output logic [DAT_W-1:0]               m_dat_o,
  output logic [N_MASTERS-1:0]           m_ack_o,
  output logic [N_MASTERS-1:0]           m_err_o,
  output logic [N_MASTERS-1:0]           m_rty_o,
  output logic [ADR_W-1:0]               s_adr_o,
  output logic [DAT_W-1:0]               s_dat_o,
  output logic [DAT_W/8-1:0]             s_sel_o,
  output logic                           s_we_o,
  output logic [N_SLAVES-1:0]            s_cyc_o,
  output logic [N_SLAVES-1:0]            s_stb_o,
  input  logic [N_SLAVES*DAT_W-1:0]      s_dat_i,
  input  logic [N_SLAVES-1:0]            s_ack_i,
  input  logic [N_SLAVES-1:0]            s_err_i,
  input  logic [N_SLAVES-1:0]            s_rty_i
);

  localparam int unsigned MW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned SW    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned SEL_W = DAT_W / 8;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state, state_nxt;
  logic [N_MASTERS-1:0]   grant, grant_nxt;
  logic [MW-1:0]          owner, last_owner, req_idx, cand_idx;
  logic                   req_found;
  int unsigned            cand;
  logic                   owned, cyc_own, stb_own;
  logic                   hit_any;
  logic [SW-1:0]          hit_idx;
  logic [N_SLAVES-1:0]    hit_vec;
  logic                   slv_ack, slv_err, slv_rty;
  logic                   err_pend, err_out, miss, miss_new, miss_done;
  logic [ADR_W-1:0]       miss_adr;
  logic                   tmo;

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++)
      if (grant[i]) owner = MW'(i);
  end

  assign owned   = (state == OWNED);
  assign cyc_own = owned & m_cyc_i[owner];
  assign stb_own = owned & m_stb_i[owner];

  // Round-robin: scan upward starting just after the last master to release the bus.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= N_MASTERS; i++) begin
      cand     = (32'(last_owner) + i) % N_MASTERS;
      cand_idx = MW'(cand);
      if (!req_found && m_cyc_i[cand_idx]) begin
        req_found = 1'b1;
        req_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (req_found) begin
          state_nxt          = OWNED;
          grant_nxt[req_idx] = 1'b1;
        end
      end
      OWNED: begin
        if (!m_cyc_i[owner]) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    if (owned) begin
      s_adr_o = m_adr_i[owner*ADR_W +: ADR_W];
      s_dat_o = m_dat_i[owner*DAT_W +: DAT_W];
      s_sel_o = m_sel_i[owner*SEL_W +: SEL_W];
      s_we_o  = m_we_i[owner];
    end
  end

  // Lowest-index matching slave wins when windows overlap.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_vec = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (!hit_any && ((s_adr_o & SLAVE_MASK[k*ADR_W +: ADR_W]) ==
                       (SLAVE_BASE[k*ADR_W +: ADR_W] & SLAVE_MASK[k*ADR_W +: ADR_W]))) begin
        hit_any    = 1'b1;
        hit_idx    = SW'(k);
        hit_vec[k] = 1'b1;
      end
    end
  end

  assign err_out = err_pend & cyc_own;

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    slv_ack = 1'b0;
    slv_err = 1'b0;
    slv_rty = 1'b0;
    if (cyc_own) begin
      s_cyc_o = hit_vec;
      if (stb_own && !tmo) s_stb_o = hit_vec;
      if (hit_any) begin
        slv_ack = s_ack_i[hit_idx];
        slv_err = s_err_i[hit_idx];
        slv_rty = s_rty_i[hit_idx];
        m_dat_o = s_dat_i[hit_idx*DAT_W +: DAT_W];
      end
    end
    if (slv_ack)                   m_ack_o = grant;
    if (slv_err || err_out || tmo) m_err_o = grant;
    if (slv_rty)                   m_rty_o = grant;
  end

  // A miss reports once; it re-arms when stb drops, the address hits, or a new address misses.
  assign miss     = cyc_own & stb_own & ~hit_any;
  assign miss_new = miss & ~(miss_done & (s_adr_o == miss_adr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_owner <= MW'(N_MASTERS - 1);
      err_pend   <= 1'b0;
      miss_done  <= 1'b0;
      miss_adr   <= '0;
    end else begin
      grant    <= grant_nxt;
      err_pend <= miss_new;
      if (owned && !m_cyc_i[owner]) last_owner <= owner;
      if (!miss) begin
        miss_done <= 1'b0;
      end else if (miss_new) begin
        miss_done <= 1'b1;
        miss_adr  <= s_adr_o;
      end
    end
  end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        any_rsp;

  assign any_rsp = slv_ack | slv_err | slv_rty | err_out;
  assign tmo     = cyc_own & stb_own & (tmo_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= '0;
    else if (!(cyc_own && stb_own) || any_rsp || tmo) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  logic unused_timeout;
  assign tmo            = 1'b0;
  assign unused_timeout = |16'(TIMEOUT);
`endif

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed + randomized bench for wb_shared_bus: decode, routing, round robin, misses, stalls, reset.
module tb_wb_shared_bus;

  localparam logic [255:0] BASE = {32'h80000000, 32'h80000000, 32'h70020000, 32'h70010000,
                                   32'h60010000, 32'h60000000, 32'h40000000, 32'h00000000};
  localparam logic [255:0] MASK = {32'hF0000000, 32'hFF000000, 32'hFFFF0000, 32'hFFFF0000,
                                   32'hFFFF0000, 32'hFFFF0000, 32'hFFF00000, 32'hFFFF0000};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  m_adr_i, m_dat_i;
  logic [7:0]   m_sel_i;
  logic [1:0]   m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]  m_dat_o;
  logic [1:0]   m_ack_o, m_err_o, m_rty_o;
  logic [31:0]  s_adr_o, s_dat_o;
  logic [3:0]   s_sel_o;
  logic         s_we_o;
  logic [7:0]   s_cyc_o, s_stb_o;
  logic [255:0] s_dat_i;
  logic [7:0]   s_ack_i, s_err_i, s_rty_i;

  int checks = 0;
  int errors = 0;
  int rr_last;
  logic [31:0] sdat[8];
  logic [31:0] sbase[8] = '{32'h00000000, 32'h40000000, 32'h60000000, 32'h60010000,
                            32'h70010000, 32'h70020000, 32'h80000000, 32'h80000000};
  logic [31:0] smask[8] = '{32'hFFFF0000, 32'hFFF00000, 32'hFFFF0000, 32'hFFFF0000,
                            32'hFFFF0000, 32'hFFFF0000, 32'hFF000000, 32'hF0000000};

  wb_shared_bus #(
    .N_MASTERS(2), .N_SLAVES(8), .ADR_W(32), .DAT_W(32),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < 8; k++)
      if ((a & smask[k]) == (sbase[k] & smask[k])) return k;
    return -1;
  endfunction

  function automatic int rr_pick(input int last, input logic [1:0] req);
    for (int i = 1; i <= 2; i++)
      if (req[(last + i) % 2]) return (last + i) % 2;
    return -1;
  endfunction

  function automatic logic [31:0] rand_in(input int sl);
    logic [31:0] r;
    r = $urandom;
    return (sbase[sl] & smask[sl]) | (r & ~smask[sl]);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_rsp();
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
  endtask

  task automatic single_txn(input int j, input logic [31:0] adr, input int rsp);
    int sl;
    logic [31:0] d;
    logic [3:0] sel;
    logic we;
    logic [7:0] oh;
    logic [1:0] jb;
    sl  = decode(adr);
    d   = $urandom;
    sel = 4'($urandom);
    we  = 1'($urandom);
    jb  = 2'b01 << j;
    oh  = (sl >= 0) ? (8'h01 << sl) : 8'h00;
    next_cycle();
    m_cyc_i[j] = 1'b1;
    m_stb_i[j] = 1'b1;
    m_we_i[j]  = we;
    m_adr_i[j*32 +: 32] = adr;
    m_dat_i[j*32 +: 32] = d;
    m_sel_i[j*4 +: 4]   = sel;
    sample();
    chk("grant_latency", 32'(s_cyc_o), 32'h0);
    next_cycle();
    if (sl >= 0) begin
      case (rsp)
        0:       s_ack_i[sl] = 1'b1;
        1:       s_err_i[sl] = 1'b1;
        default: s_rty_i[sl] = 1'b1;
      endcase
    end
    sample();
    chk("s_adr", s_adr_o, adr);
    chk("s_dat", s_dat_o, d);
    chk("s_sel", 32'(s_sel_o), 32'(sel));
    chk("s_we", 32'(s_we_o), 32'(we));
    chk("s_cyc", 32'(s_cyc_o), 32'(oh));
    chk("s_stb", 32'(s_stb_o), 32'(oh));
    if (sl >= 0) begin
      chk("m_ack", 32'(m_ack_o), (rsp == 0) ? 32'(jb) : 32'h0);
      chk("m_err", 32'(m_err_o), (rsp == 1) ? 32'(jb) : 32'h0);
      chk("m_rty", 32'(m_rty_o), (rsp >= 2) ? 32'(jb) : 32'h0);
      chk("m_dat", m_dat_o, sdat[sl]);
    end else begin
      chk("miss_err_early", 32'(m_err_o), 32'h0);
      next_cycle();
      sample();
      chk("miss_err", 32'(m_err_o), 32'(jb));
      next_cycle();
      sample();
      chk("miss_err_once", 32'(m_err_o), 32'h0);
    end
    next_cycle();
    clear_rsp();
    m_cyc_i[j] = 1'b0;
    m_stb_i[j] = 1'b0;
    if (sl >= 0) s_ack_i[sl] = 1'b1;
    sample();
    chk("late_ack", 32'(m_ack_o), 32'h0);
    chk("release_cyc", 32'(s_cyc_o), 32'h0);
    next_cycle();
    clear_rsp();
    rr_last = j;
  endtask

  initial begin
    int rem[2];
    logic [31:0] ra[2];
    logic [1:0] rq;
    int g, sl, first, errseen;
    logic [31:0] hold_a[3];
    logic [7:0] stb_at;

    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    clear_rsp();
    for (int k = 0; k < 8; k++) sdat[k] = $urandom;
    sdat[4] = 32'hDEADBEEF;
    for (int k = 0; k < 8; k++) s_dat_i[k*32 +: 32] = sdat[k];
    rr_last = 1;

    repeat (2) sample();
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("rst_m_err", 32'(m_err_o), 32'h0);
    chk("rst_m_rty", 32'(m_rty_o), 32'h0);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_s_dat", s_dat_o, 32'h0);
    chk("rst_s_sel", 32'(s_sel_o), 32'h0);
    chk("rst_s_we", 32'(s_we_o), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    single_txn(0, 32'h70010004, 0);
    single_txn(1, 32'h30000000, 0);
    single_txn(0, 32'h80123456, 1);
    single_txn(1, 32'h8F000000, 2);

    for (int n = 0; n < 16; n++) begin
      int j, k, rsp;
      logic [31:0] a;
      j   = $urandom_range(0, 1);
      k   = $urandom_range(0, 4);
      a   = (k == 0) ? {4'h3, 28'($urandom)} : rand_in($urandom_range(0, 7));
      rsp = $urandom_range(0, 2);
      single_txn(j, a, rsp);
    end

    // Both masters contend for four transfers each.
    rem[0] = 4;
    rem[1] = 4;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      ra[i] = rand_in($urandom_range(0, 7));
      m_cyc_i[i] = 1'b1;
      m_stb_i[i] = 1'b1;
      m_adr_i[i*32 +: 32] = ra[i];
    end
    while (rem[0] + rem[1] > 0) begin
      sample();
      chk("rr_idle", 32'(s_cyc_o), 32'h0);
      rq[0] = rem[0] > 0;
      rq[1] = rem[1] > 0;
      g = rr_pick(rr_last, rq);
      next_cycle();
      sl = decode(ra[g]);
      s_ack_i[sl] = 1'b1;
      sample();
      chk("rr_adr", s_adr_o, ra[g]);
      chk("rr_ack", 32'(m_ack_o), 32'(2'b01 << g));
      next_cycle();
      clear_rsp();
      m_cyc_i[g] = 1'b0;
      m_stb_i[g] = 1'b0;
      rem[g]--;
      rr_last = g;
      sample();
      chk("rr_release", 32'(s_cyc_o), 32'h0);
      next_cycle();
      if (rem[g] > 0) begin
        ra[g] = rand_in($urandom_range(0, 7));
        m_cyc_i[g] = 1'b1;
        m_stb_i[g] = 1'b1;
        m_adr_i[g*32 +: 32] = ra[g];
      end
    end

    // Master 0 holds its cycle over three transfers while master 1 waits.
    hold_a[0] = 32'h00000100;
    hold_a[1] = 32'h70020004;
    hold_a[2] = 32'h60000008;
    next_cycle();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_adr_i[31:0] = hold_a[0];
    sample();
    chk("hold_latency", 32'(s_cyc_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      clear_rsp();
      m_cyc_i[1] = 1'b1;
      m_stb_i[1] = 1'b1;
      m_adr_i[63:32] = 32'h80000010;
      m_adr_i[31:0] = hold_a[k];
      s_ack_i[decode(hold_a[k])] = 1'b1;
      sample();
      chk("hold_adr", s_adr_o, hold_a[k]);
      chk("hold_ack", 32'(m_ack_o), 32'h1);
    end
    next_cycle();
    clear_rsp();
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    sample();
    chk("hold_release", 32'(s_cyc_o), 32'h0);
    next_cycle();
    sample();
    chk("hold_gap", 32'(s_cyc_o), 32'h0);
    next_cycle();
    s_ack_i[6] = 1'b1;
    sample();
    chk("hold_m1_adr", s_adr_o, 32'h80000010);
    chk("hold_m1_ack", 32'(m_ack_o), 32'h2);
    next_cycle();
    clear_rsp();
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    rr_last = 1;
    next_cycle();

    single_txn(0, 32'h40000020, 0);

    // Slave 5 never answers.
    next_cycle();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_we_i[0]  = 1'b0;
    m_adr_i[31:0] = 32'h70020000;
    next_cycle();
`ifdef WB_SHARED_BUS_TIMEOUT_EN
    first  = -1;
    stb_at = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (first < 0 && m_err_o[0]) begin
        first  = i;
        stb_at = s_stb_o;
      end
      next_cycle();
    end
    chk("tmo_cycle", 32'(first), 32'd16);
    chk("tmo_stb_forced", 32'(stb_at), 32'h0);
`else
    errseen = 0;
    for (int i = 0; i < 1000; i++) begin
      sample();
      if (m_err_o != 2'b00) errseen = 1;
      next_cycle();
    end
    sample();
    chk("stall_stb", 32'(s_stb_o), 32'h20);
    chk("stall_no_err", 32'(errseen), 32'h0);
    next_cycle();
`endif
    m_cyc_i[0] = 1'b0;
    m_stb_i[0] = 1'b0;
    next_cycle();
    rr_last = 0;
    next_cycle();

    // Reset during an SRAM access owned by master 1.
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    m_we_i[1]  = 1'b0;
    m_adr_i[63:32] = 32'h40000010;
    next_cycle();
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    m_adr_i[31:0] = 32'h00000040;
    s_ack_i[1] = 1'b1;
    sample();
    chk("pre_rst_cyc", 32'(s_cyc_o), 32'h02);
    chk("pre_rst_ack", 32'(m_ack_o), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_async_ack", 32'(m_ack_o), 32'h0);
    chk("rst_async_stb", 32'(s_stb_o), 32'h0);
    chk("rst_async_adr", s_adr_o, 32'h0);
    rr_last = 1;
    next_cycle();
    clear_rsp();
    rst_n = 1'b1;
    sample();
    chk("post_rst_idle", 32'(s_cyc_o), 32'h0);
    g = rr_pick(rr_last, 2'b11);
    next_cycle();
    sample();
    chk("post_rst_grant", s_adr_o, (g == 0) ? 32'h00000040 : 32'h40000010);
    chk("post_rst_cyc", 32'(s_cyc_o), (g == 0) ? 32'h01 : 32'h02);
    next_cycle();
    m_cyc_i = '0;
    m_stb_i = '0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus.md
Name: wb_shared_bus

Overview:
Parametrised Wishbone shared-bus interconnect for the LM32 SoC tops. It replaces the fixed 8x8 conbus with N masters and M slaves, set per-slave decode masks and round-robin arbitration. It also generates bus errors for unmapped addresses and stalled slaves. It sits between the CPU I/D ports and the peripherals: BRAM, SRAM, UART, timer, GPIO and farbborg.

Parameters:
N_MASTERS, 2, number of master ports (1..8)
N_SLAVES, 8, number of slave ports (1..16)
ADR_W, 32, address width
DAT_W, 32, data width (multiple of 8)
SLAVE_BASE, {N_SLAVES{32'h0}}, flattened N_SLAVES*ADR_W base addresses; slave i is bits [i*ADR_W +: ADR_W]
SLAVE_MASK, {N_SLAVES{32'h0}}, flattened per-slave compare masks; slave i matches when (adr & mask_i) == (base_i & mask_i)
TIMEOUT, 255, cycles of unanswered stb before an error is forced (1..65535)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
m_adr_i  in  N_MASTERS*ADR_W  master addresses, master j at [j*ADR_W +: ADR_W]
m_dat_i  in  N_MASTERS*DAT_W  master write data
m_sel_i  in  N_MASTERS*DAT_W/8  master byte selects
m_we_i  in  N_MASTERS  master write enables
m_cyc_i  in  N_MASTERS  master cycle requests
m_stb_i  in  N_MASTERS  master strobes
m_dat_o  out  DAT_W  read data, broadcast to all masters
m_ack_o  out  N_MASTERS  per-master acknowledge
m_err_o  out  N_MASTERS  per-master error
m_rty_o  out  N_MASTERS  per-master retry
s_adr_o  out  ADR_W  shared slave address (granted master's)
s_dat_o  out  DAT_W  shared slave write data
s_sel_o  out  DAT_W/8  shared byte selects
s_we_o  out  1  shared write enable
s_cyc_o  out  N_SLAVES  per-slave cycle, decoded
s_stb_o  out  N_SLAVES  per-slave strobe, decoded
s_dat_i  in  N_SLAVES*DAT_W  slave read data
s_ack_i  in  N_SLAVES  slave acknowledge
s_err_i  in  N_SLAVES  slave error
s_rty_i  in  N_SLAVES  slave retry

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, grant one-hot = 0, last_owner = N_MASTERS-1, timeout counter = 0, err_pend = 0. All s_cyc_o/s_stb_o/m_ack_o/m_err_o/m_rty_o read 0; s_adr_o/s_dat_o/s_sel_o/s_we_o read 0.
- FSM IDLE: if any m_cyc_i is high, grant the first requester found scanning upward from last_owner+1 modulo N_MASTERS. Go to OWNED on the next edge. Grant latency is one cycle from cyc to s_cyc_o.
- FSM OWNED: the granted master's adr/dat/sel/we are muxed to the shared slave outputs; the non-granted masters see ack/err/rty = 0.
  - Decode is combinational on s_adr_o. The lowest-index matching slave wins. s_cyc_o[k] = cyc_owner & hit_k, and s_stb_o[k] = stb_owner & hit_k.
  - Slave ack/err/rty/dat are routed combinationally back to the owner, with zero added latency.
- Ownership is held while m_cyc_i[owner] stays high, so multi-transfer cycles (e.g. RMW) are not interruptible. When cyc drops: last_owner <= owner, return to IDLE. A new grant can issue on the cycle after the release edge.
- Unmapped address (no hit, owner stb high): register err_pend. m_err_o[owner] is 1 for exactly one cycle, on the cycle after stb is sampled. It is not repeated until stb has been low or the address changes and then misses again.
- Simultaneous requests: round robin guarantees each requesting master a grant within N_MASTERS ownership periods.
- Owner drops cyc mid-transfer: ownership ends at that edge; any late slave ack is ignored (not routed).
- rst_n asserted mid-transfer: all outputs go to 0 immediately; arbitration restarts at master 0.

Optional Feature:
WB_SHARED_BUS_TIMEOUT_EN
- Defined: a 16-bit counter clears on IDLE, on any owner ack/err/rty, and while owner stb is low; it increments while owner stb is high with no response.
  - When it reaches TIMEOUT, m_err_o[owner] pulses for 1 cycle, s_stb_o is forced low that cycle, and the counter clears.
- Not defined: no counter is built; a stalled slave hangs the bus indefinitely.

Test Plan:
- Master0 read 0x70010004 (timer at base 0x70010000, mask 0xFFFF0000), slave acks on the first stb cycle with 0xDEADBEEF -> s_cyc_o one-hot bit 4, m_dat_o=0xDEADBEEF, m_ack_o=2'b01 in the same cycle as s_ack_i.
- Masters 0 and 1 raise cyc in the same cycle, repeated 4 transactions each -> grants alternate 0,1,0,1,...; one idle cycle between release and the next grant.
- Master1 writes 0x30000000 (unmapped) -> no s_cyc_o bit set; m_err_o[1] high for exactly 1 cycle, one cycle after stb.
- With TIMEOUT_EN defined and TIMEOUT=16, a slave that never acks -> m_err_o pulses exactly 16 cycles after stb rises. Without the macro, stb is still held after 1000 cycles.
- Master0 holds cyc across 3 back-to-back acked transfers while master1 requests -> master1 is granted only after master0 drops cyc.
- rst_n pulled low during an outstanding SRAM read -> all s_cyc_o/m_ack_o are 0 asynchronously; after release, master0 is granted first.
